register_universal: RTL and testbench

Parametrised successor to the fixed 32-bit parallel register. Provides a WIDTH-bit storage register with byte-enabled parallel load and a multi-cycle shift/rotate engine. The engine shifts one bit per clock under a start/busy/done handshake. Used by datapath blocks that need a shift-capable architectural register, such as a multicycle shifter or serial I/O staging, without a barrel shifter.

---
 rtl/register_universal_pkg.sv | 17 +
 rtl/dff.sv | 22 ++
 rtl/shift_step.sv | 35 +++
 rtl/register_universal.sv | 127 ++++++++++++
 tb/tb_register_universal.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/register_universal_pkg.sv
// register_universal_pkg
//   Shared definitions for the universal shift register:
//   - shift op encodings carried on the op port
//   - FSM state encoding used by the top-level control
package register_universal_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/dff.sv
// dff
//   Single storage bit with asynchronous active-low reset to RESET_VAL.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-low reset
//     d    - next value
//     q    - stored value
module dff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= RESET_VAL;
    else      q <= d;
  end

endmodule

// File: rtl/shift_step.sv
// shift_step
//   Combinational single-bit step of the shift engine.
//   Ports:
//     op        - shift type (OP_SLL / OP_SRL / OP_SRA / OP_ROR)
//     cur       - current register value
//     serial_in - fill bit used by SLL and SRL
//     nxt       - register value after one step
//     bit_out   - bit leaving the register on this step
module shift_step
  import register_universal_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] cur,
  input  logic             serial_in,
  output logic [WIDTH-1:0] nxt,
  output logic             bit_out
);

  always_comb begin
    nxt     = cur;
    bit_out = cur[0];
    case (op)
      OP_SLL: begin
        nxt     = {cur[WIDTH-2:0], serial_in};
        bit_out = cur[WIDTH-1];
      end
      OP_SRL:  nxt = {serial_in, cur[WIDTH-1:1]};
      OP_SRA:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: nxt = {cur[0], cur[WIDTH-1:1]};  // OP_ROR
    endcase
  end

endmodule

// File: rtl/register_universal.sv
// register_universal
//   WIDTH-bit register with byte-enabled parallel load and a one-bit-per-clock
//   shift/rotate engine.
//   Ports:
//     clk, rst         - clock, asynchronous active-low reset
//     we, be, D        - parallel write (IDLE only); be[i] covers Q[8i+7:8i]
//     start, op, shamt - shift request (IDLE only); op latched at accept
//     serial_in        - fill bit for SLL/SRL, sampled on every step
//     Q                - register contents
//     serial_out       - last bit shifted/rotated out (held between ops)
//     busy             - FSM is in SHIFT (direct decode of the state register)
//     done             - registered one-cycle completion pulse
//
//   Handshake: start is sampled only while busy=0. A request with shamt=n>0
//   raises busy on the accepting edge, performs n steps on the next n edges,
//   and on the final step edge busy drops and done rises for exactly one
//   cycle. shamt=0 gives done one cycle after the accepting edge with busy
//   never raised. A load (we=1) in the same cycle as start wins and the
//   request is dropped. Because done is only raised as the FSM returns to
//   IDLE, a new start may be presented in the done cycle.
module register_universal
  import register_universal_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               SHAMT_W     = 5,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH-1:0]   D,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               serial_in,
  output logic [WIDTH-1:0]   Q,
  output logic               serial_out,
  output logic               busy,
  output logic               done
);

  localparam int NBYTES = WIDTH / 8;

  state_t             state, state_next;
  logic [SHAMT_W-1:0] cnt, cnt_next;
  logic [1:0]         op_q, op_next;
  logic [WIDTH-1:0]   q_next;
  logic [WIDTH-1:0]   step_q;
  logic               step_bit;
  logic               sout_next;
  logic               done_next;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op        (op_q),
    .cur       (Q),
    .serial_in (serial_in),
    .nxt       (step_q),
    .bit_out   (step_bit)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    op_next    = op_q;
    q_next     = Q;
    sout_next  = serial_out;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (we) begin
          for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) q_next[8*i +: 8] = D[8*i +: 8];
          end
        end else if (start) begin
          if (shamt == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = ST_SHIFT;
            cnt_next   = shamt;
            op_next    = op;
          end
        end
      end
      ST_SHIFT: begin
        q_next    = step_q;
        sout_next = step_bit;
        cnt_next  = cnt - SHAMT_W'(1);
        // cnt==1 means this edge performs the last step.
        if (cnt == SHAMT_W'(1)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_q       <= OP_SLL;
      serial_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      op_q       <= op_next;
      serial_out <= sout_next;
      done       <= done_next;
    end
  end

  // Storage bits, each resetting to its own bit of RESET_VALUE.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    dff #(.RESET_VAL(RESET_VALUE[i])) u_bit (
      .clk (clk),
      .rst (rst),
      .d   (q_next[i]),
      .q   (Q[i])
    );
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_register_universal.sv
module tb_register_universal;
  import register_universal_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  be;
  logic [31:0] d;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic        serial_in;
  logic [31:0] q;
  logic        serial_out;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  register_universal dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .be         (be),
    .D          (d),
    .start      (start),
    .op         (op),
    .shamt      (shamt),
    .serial_in  (serial_in),
    .Q          (q),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] d;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] exp_q;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_sout;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver / checker tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [31:0] eq, input logic eb,
                         input logic ed, input logic es);
    chk({nm, ".q"},    q,                  eq);
    chk({nm, ".busy"}, {31'd0, busy},       {31'd0, eb});
    chk({nm, ".done"}, {31'd0, done},       {31'd0, ed});
    chk({nm, ".sout"}, {31'd0, serial_out}, {31'd0, es});
  endtask

  task automatic idle_inputs();
    we = 1'b0; be = 4'h0; d = 32'h0; start = 1'b0;
    op = OP_SLL; shamt = 5'd0; serial_in = 1'b0;
  endtask

  // Hard stop if anything hangs.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic [31:0] sra_exp[3];
    int busy_cnt;
    int done_cnt;
    bit seen;

    // Per-cycle vectors: inputs applied before an edge, outputs checked after.
    vecs[0] = '{1'b1, 4'b0101, 32'hAABBCCDD, 1'b0, OP_SLL, 5'd0, 32'h00BB00DD, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'b1111, 32'h12345678, 1'b0, OP_SLL, 5'd0, 32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'b0000, 32'hFFFFFFFF, 1'b0, OP_SLL, 5'd0, 32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 4'b1000, 32'h9A000000, 1'b0, OP_SLL, 5'd0, 32'h9A345678, 1'b0, 1'b0, 1'b0};
    // load and start together: load wins, no shift, no done
    vecs[4] = '{1'b1, 4'b1111, 32'h80000010, 1'b1, OP_SRA, 5'd4, 32'h80000010, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 4'b0000, 32'h00000000, 1'b0, OP_SLL, 5'd0, 32'h80000010, 1'b0, 1'b0, 1'b0};
    // zero-length shift: done only
    vecs[6] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, OP_SRL, 5'd0, 32'h80000010, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 4'b0000, 32'h00000000, 1'b0, OP_SLL, 5'd0, 32'h80000010, 1'b0, 1'b0, 1'b0};

    sra_exp[0] = 32'hC0000008;
    sra_exp[1] = 32'hE0000004;
    sra_exp[2] = 32'hF0000002;

    // Reset for two cycles, then release.
    idle_inputs();
    rst = 1'b0;
    cycle();
    chk_all("reset_hold", 32'h0, 1'b0, 1'b0, 1'b0);
    cycle();
    rst = 1'b1;
    cycle();
    chk_all("reset_idle", 32'h0, 1'b0, 1'b0, 1'b0);

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we; be = vecs[i].be; d = vecs[i].d;
      start = vecs[i].start; op = vecs[i].op; shamt = vecs[i].shamt;
      cycle();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_busy,
              vecs[i].exp_done, vecs[i].exp_sout);
    end
    idle_inputs();

    // SRA by 4 from 0x80000010, with we/start noise while busy.
    op = OP_SRA; shamt = 5'd4; start = 1'b1;
    cycle();
    chk_all("sra_accept", 32'h80000010, 1'b1, 1'b0, 1'b0);
    we = 1'b1; be = 4'hF; d = 32'h0; start = 1'b1; op = OP_SLL; shamt = 5'd1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_all($sformatf("sra_step%0d", i + 1), sra_exp[i], 1'b1, 1'b0, 1'b0);
    end
    idle_inputs();
    cycle();
    chk_all("sra_done", 32'hF8000001, 1'b0, 1'b1, 1'b0);
    cycle();
    chk_all("sra_after", 32'hF8000001, 1'b0, 1'b0, 1'b0);

    // Load 0x12345678 then ROR by 8, measuring busy length.
    we = 1'b1; be = 4'hF; d = 32'h12345678;
    cycle();
    idle_inputs();
    chk("ror_load", q, 32'h12345678);
    op = OP_ROR; shamt = 5'd8; start = 1'b1;
    cycle();
    idle_inputs();
    chk("ror_accept_busy", {31'd0, busy}, 32'd1);
    busy_cnt = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
    chk("ror_done_seen", {31'd0, seen}, 32'd1);
    chk("ror_busy_cycles", busy_cnt, 32'd8);
    chk_all("ror_done", 32'h78123456, 1'b0, 1'b1, 1'b0);

    // New SLL accepted in the done cycle, streaming serial_in = 1,0,1.
    op = OP_SLL; shamt = 5'd3; start = 1'b1;
    cycle();
    chk_all("sll_accept", 32'h78123456, 1'b1, 1'b0, 1'b0);
    start = 1'b0; serial_in = 1'b1;
    cycle();
    chk_all("sll_step1", 32'hF02468AD, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b0;
    cycle();
    chk_all("sll_step2", 32'hE048D15A, 1'b1, 1'b0, 1'b1);
    serial_in = 1'b1;
    cycle();
    chk_all("sll_done", 32'hC091A2B5, 1'b0, 1'b1, 1'b1);
    idle_inputs();

    // Load then check serial_out is untouched by a parallel write.
    we = 1'b1; be = 4'hF; d = 32'h0000FFFF;
    cycle();
    idle_inputs();
    chk_all("load_keeps_sout", 32'h0000FFFF, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of an SRL by 10.
    op = OP_SRL; shamt = 5'd10; start = 1'b1; serial_in = 1'b0;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk_all("srl_mid", 32'h00001FFF, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    cycle();
    rst = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    chk("post_reset_done_pulses", done_cnt, 32'd0);
    chk("post_reset_busy_cycles", busy_cnt, 32'd0);
    chk("post_reset_q", q, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
